// File: rtl/data_mem_responder.sv
// data_mem_responder: slow big-endian data memory behind a valid/ready request channel
module data_mem_responder #(
  parameter int          BYTES   = 1024,
  parameter logic [31:0] START   = 32'h10008000,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);
  localparam int AW = $clog2(BYTES);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0]  cnt;
  logic        lat_write, lat_err;
  logic [31:0] lat_addr, lat_wdata, rdata_q;
  logic [3:0]  lat_be;
  logic [7:0]  mem [BYTES];
  logic        accept, err_now, commit, c_write;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_be;
  logic [AW-1:0] off;
  logic [32:0] a33;
  assign accept  = state == IDLE && req_valid;
  assign a33     = {1'b0, req_addr};
  assign err_now = req_addr[1:0] != 2'b00 || a33 < {1'b0, START} || a33 > {1'b0, START} + 33'(BYTES - 4);
  // a single-cycle build commits straight from the request inputs in the accept cycle
  assign c_write = state == IDLE ? req_write : lat_write;
  assign c_addr  = state == IDLE ? req_addr  : lat_addr;
  assign c_wdata = state == IDLE ? req_wdata : lat_wdata;
  assign c_be    = state == IDLE ? req_be    : lat_be;
  assign off     = AW'(c_addr - START);
  assign commit  = (accept && !err_now && LATENCY == 1) || (state == WAIT && cnt == 4'd0);
  always_ff @(posedge clk)
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (accept ? ((err_now || LATENCY == 1) ? RESP : WAIT) : IDLE) :
               state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rdata_q   <= '0;
      for (int i = 0; i < BYTES; i++) mem[i] <= 8'h00;
    end else begin
      rdata_q <= '0;
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        lat_err   <= err_now;
        cnt       <= 4'(LATENCY - 2);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && c_write)
        for (int k = 0; k < 4; k++)
          if (c_be[3-k]) mem[off + AW'(k)] <= c_wdata[31-8*k -: 8];
      if (commit && !c_write)
        rdata_q <= {mem[off], mem[off + AW'(1)], mem[off + AW'(2)], mem[off + AW'(3)]};
    end
  end
  always_comb begin
    req_ready  = state == IDLE;
    resp_valid = state == RESP;
    resp_error = state == RESP && lat_err;
    resp_rdata = state == RESP ? rdata_q : '0;
    busy       = state != IDLE;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: four latency builds driven in parallel against a transaction-level model
module tb_data_mem_responder;
  localparam int          BYTES = 1024;
  localparam longint      START = 64'h10008000;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic [3:0]  req_ready, resp_valid, resp_error, busy;
  logic [31:0] resp_rdata [4];
  int checks = 0, errors = 0, cyc = 0;
  bit armed = 0;
  bit          idle_m [4];
  int          k_m [4], lr_m [4];
  logic [31:0] rd_m [4];
  bit          er_m [4];
  logic [7:0]  mm [4][BYTES];
  logic        v1, e1, v2, e2, b1, b2;
  logic [31:0] rd1, rd2, rd5;
  int q1[$], q5[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_mem_responder #(.BYTES(BYTES), .START(32'h10008000), .LATENCY(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 4 : 5)) u_dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready[g]), .req_write(req_write),
      .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]), .resp_error(resp_error[g]), .busy(busy[g]));
  end
  function automatic int lat_of(int d);
    return d == 0 ? 1 : d == 1 ? 2 : d == 2 ? 4 : 5;
  endfunction
  function automatic bit bad(logic [31:0] a);
    longint x = longint'({32'b0, a});
    return a[1:0] != 2'b00 || x < START || x > START + BYTES - 4;
  endfunction
  // transaction-level model: the whole access happens at accept, then the response is timed out
  task automatic model_step();
    bit e;
    int o;
    for (int d = 0; d < 4; d++) begin
      if (!rstn) begin
        idle_m[d] = 1;
        for (int i = 0; i < BYTES; i++) mm[d][i] = 8'h00;
      end else if (idle_m[d]) begin
        if (req_valid) begin
          e = bad(req_addr);
          o = int'(req_addr - 32'h10008000);
          idle_m[d] = 0; k_m[d] = 1; lr_m[d] = e ? 1 : lat_of(d); er_m[d] = e; rd_m[d] = '0;
          if (!e)
            for (int b = 0; b < 4; b++)
              if (req_write) begin
                if (req_be[3-b]) mm[d][o+b] = req_wdata[31-8*b -: 8];
              end else rd_m[d][31-8*b -: 8] = mm[d][o+b];
        end
      end else if (k_m[d] == lr_m[d]) idle_m[d] = 1;
      else k_m[d]++;
    end
    if (!rstn) armed = 1;
  endtask
  always @(posedge clk) model_step();
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk)
    if (armed)
      for (int d = 0; d < 4; d++) begin
        automatic bit v = !idle_m[d] && k_m[d] == lr_m[d];
        chk($sformatf("ready[L%0d]", lat_of(d)), 32'(req_ready[d]), 32'(idle_m[d]));
        chk($sformatf("busy[L%0d]", lat_of(d)), 32'(busy[d]), 32'(!idle_m[d]));
        chk($sformatf("resp_valid[L%0d]", lat_of(d)), 32'(resp_valid[d]), 32'(v));
        chk($sformatf("resp_error[L%0d]", lat_of(d)), 32'(resp_error[d]), 32'(v && er_m[d]));
        chk($sformatf("resp_rdata[L%0d]", lat_of(d)), resp_rdata[d], v ? rd_m[d] : 32'h0);
      end
  // one request in cycle 0, observed on the LATENCY=2 build (cycles 1,2) and LATENCY=5 build (cycle 5)
  task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input bit scr);
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = a; req_be = be; req_wdata = wd;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      req_valid = 0;
      if (scr) begin req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom); req_write = 1'($urandom); end
      if (c == 1) begin v1 = resp_valid[1]; e1 = resp_error[1]; rd1 = resp_rdata[1]; b1 = busy[1] & !req_ready[1]; end
      if (c == 2) begin v2 = resp_valid[1]; e2 = resp_error[1]; rd2 = resp_rdata[1]; b2 = busy[1] & !req_ready[1]; end
      if (c == 5) rd5 = resp_rdata[3];
    end
  endtask
  initial begin
    int pv;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready[1]), 1);
    chk("rst_valid", 32'(resp_valid[1]), 0);
    chk("rst_busy", 32'(busy[1]), 0);
    rstn = 1;
    txn(1, 32'h10008000, 4'b1111, 32'hDEADBEEF, 0);
    chk("t1_store_v2", 32'(v2), 1); chk("t1_store_err", 32'(e2), 0); chk("t1_store_rdata", rd2, 0);
    txn(0, 32'h10008000, 4'b0000, 32'h0, 0);
    chk("t1_load_rdata", rd2, 32'hDEADBEEF); chk("t1_load_busy1", 32'(b1), 1); chk("t1_load_busy2", 32'(b2), 1);
    txn(1, 32'h10008004, 4'b1111, 32'h11223344, 0);
    txn(1, 32'h10008004, 4'b0101, 32'hAABBCCDD, 0);
    txn(0, 32'h10008004, 4'b0000, 32'h0, 0);
    chk("t2_partial", rd2, 32'h11BB33DD);
    txn(0, 32'h10008002, 4'b0000, 32'h0, 0);
    chk("t3_misalign_v1", 32'(v1), 1); chk("t3_misalign_err", 32'(e1), 1); chk("t3_misalign_rdata", rd1, 0);
    txn(1, 32'h100083FC, 4'b1111, 32'hCAFEF00D, 0);
    txn(1, 32'h10008400, 4'b1111, 32'h99999999, 0);
    chk("t3_top_err", 32'(e1), 1);
    txn(0, 32'h100083FC, 4'b0000, 32'h0, 0);
    chk("t3_top_unchanged", rd2, 32'hCAFEF00D);
    txn(0, 32'h10007FFC, 4'b0000, 32'h0, 0);
    chk("t3_below_err", 32'(e1), 1);
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk);
      if (resp_valid[0]) q1.push_back(c);
      if (resp_valid[3]) q5.push_back(c);
      req_valid = c < 19; req_write = 0; req_addr = 32'h10008000;
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_l1_resp%0d", i), i < q1.size() ? q1[i] : -1, 1 + 2 * i);
      chk($sformatf("t4_l5_resp%0d", i), i < q5.size() ? q5[i] : -1, 5 + 6 * i);
    end
    repeat (6) @(negedge clk);
    pv = 0;
    req_valid = 1; req_write = 1; req_addr = 32'h10008010; req_be = 4'b1111; req_wdata = 32'h12345678;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      req_valid = 0;
      pv += int'(resp_valid[2]);
      if (c == 2) rstn = 0;
      if (c == 3) rstn = 1;
    end
    chk("t5_no_pulse", pv, 0);
    txn(0, 32'h10008010, 4'b0000, 32'h0, 0);
    chk("t5_cleared_l2", rd2, 0); chk("t5_cleared_l5", rd5, 0);
    txn(1, 32'h10008020, 4'b1111, 32'h0BADF00D, 1);
    txn(0, 32'h10008020, 4'b0000, 32'h0, 1);
    chk("t6_hold_l5", rd5, 32'h0BADF00D); chk("t6_hold_l2", rd2, 32'h0BADF00D);
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rstn = $urandom_range(0, 99) != 0;
      req_valid = 1'($urandom); req_write = 1'($urandom); req_be = 4'($urandom); req_wdata = $urandom;
      case ($urandom_range(0, 9))
        0: req_addr = 32'h10008000 + $urandom_range(0, 63);
        1: req_addr = 32'h10007FFC;
        2: req_addr = 32'h10008400;
        3: req_addr = 32'h100083FC;
        4: req_addr = $urandom;
        default: req_addr = 32'h10008000 + 4 * $urandom_range(0, 15);
      endcase
    end
    rstn = 1; req_valid = 0;
    repeat (8) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
